// File: rtl/scard_pkg.sv
// -----------------------------------------------------------------------------
// scard_pkg
// Shared definitions for the smart-card async receiver: FSM state encoding,
// oversampling constants, the oversample divider calculation and the 3-sample
// majority vote.
// Also provides a default for the `UART_CLK macro (system clock in Hz) when
// the build does not supply one.
// -----------------------------------------------------------------------------
`ifndef UART_CLK
`define UART_CLK 40000000
`endif

package scard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_NACK   = 3'd5
  } state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int NACK_TICKS = 16;

  // Ticks within one bit: samples at 7,8,9; decision at 9; bit ends at 15.
  localparam logic [3:0] TICK_SAMP0     = 4'd7;
  localparam logic [3:0] TICK_SAMP1     = 4'd8;
  localparam logic [3:0] TICK_DECIDE    = 4'd9;
  localparam logic [3:0] TICK_LAST      = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_NACK_LAST = 4'(NACK_TICKS - 1);
  localparam logic [2:0] LAST_DATA_BIT  = 3'(DATA_BITS - 1);

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int div_calc(input longint clk_freq, input longint baud);
    longint den;
    longint q;
    den = baud * longint'(OVERSAMPLE);
    q   = (clk_freq + (den / 64'sd2)) / den;
    if (q < 64'sd1) begin
      q = 64'sd1;
    end
    return int'(q);
  endfunction

  // 2-of-3 majority vote over the samples of one bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/scard_baud_tick.sv
// -----------------------------------------------------------------------------
// scard_baud_tick
// Oversample divider: produces a one-clock tick every DIV clocks. A synchronous
// restart zeroes the divider so that the first tick after restart lands DIV
// clocks later, aligning tick phase to the detected start edge.
// Ports:
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset
//   i_restart in  synchronous divider restart
//   o_tick    out one-clock tick, registered
// -----------------------------------------------------------------------------
module scard_baud_tick #(
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_tick;

  // Next divider count: restart and wrap both return to zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_restart) begin
      w_cnt_nxt = CNT_ZERO;
    end else if (r_cnt == DIV_LAST) begin
      w_cnt_nxt = CNT_ZERO;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  // Divider register; the tick is high in every cycle the count sits at DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= CNT_ZERO;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == DIV_LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/async_receiver_scard.sv
// -----------------------------------------------------------------------------
// async_receiver_scard
// ISO7816-3 (T=0 style) smart-card serial receiver. Frame: start(0), 8 data
// bits LSB first, even parity, 2 stop/guard bits. 16x oversampling with a
// 3-sample majority vote per bit.
// Optional feature macro: SCARD_NACK_EN -- on a parity error the receiver
// drives RxD_nack_oe for one ETU starting at the stop-bit decision. Without it
// RxD_nack_oe is tied low and the NACK state is not built.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   RxD            in   serial line, asynchronous, idle high
//   RxD_data       out  last received byte
//   RxD_data_ready out  one-clock pulse when data/flags update
//   RxD_parity_err out  parity error of last byte
//   RxD_frame_err  out  first stop bit sampled low
//   RxD_busy       out  frame reception in progress
//   RxD_nack_oe    out  drive line low (error signal)
// -----------------------------------------------------------------------------
`ifndef UART_CLK
`define UART_CLK 40000000
`endif

module async_receiver_scard
  import scard_pkg::*;
#(
  parameter int CLK_FREQ = `UART_CLK,
  parameter int BAUD     = 9600,
  parameter int DIV_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_parity_err,
  output logic       RxD_frame_err,
  output logic       RxD_busy,
  output logic       RxD_nack_oe
);

  localparam int DIV = div_calc(longint'(CLK_FREQ), longint'(BAUD));

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_sync_vld;
  logic       r_armed;
  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_s7;
  logic       r_s8;
  logic [7:0] r_shift;
  logic       r_perr_pend;
  logic [7:0] r_data;
  logic       r_ready;
  logic       r_perr;
  logic       r_ferr;
  logic       r_busy;

  logic w_rxd;
  logic w_tick;
  logic w_maj;
  logic w_decide;
  logic w_bit_end;
  logic w_start;
  logic w_load;

  scard_baud_tick #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_restart (w_start),
    .o_tick    (w_tick)
  );

  assign w_rxd     = r_sync2;
  // Third vote is the live synced line at the decision tick.
  assign w_maj     = maj3(r_s7, r_s8, w_rxd);
  assign w_decide  = w_tick & (r_tick_cnt == TICK_DECIDE);
  assign w_bit_end = w_tick & (r_tick_cnt == TICK_LAST);
  assign w_start   = (r_state == ST_IDLE) & r_armed & ~w_rxd;
  assign w_load    = (r_state == ST_STOP) & w_decide;

  // Two-flop synchronizer; r_sync_vld marks when r_sync2 holds a real line sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync1    <= RxD;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Arming: a start is only accepted after the line has genuinely been seen
  // high, so the reset value of the synchronizer cannot arm a held-low line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
    end else if (r_state == ST_NACK) begin
      r_armed <= 1'b0;
    end else if (r_sync_vld[1] & w_rxd) begin
      r_armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = ST_START;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_decide && w_maj) begin
          w_next = ST_IDLE;
        end else if (w_bit_end) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_DATA_BIT)) begin
          w_next = ST_PARITY;
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_next = ST_STOP;
        end else begin
          w_next = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Leave at the first stop-bit decision; the guard bit is not checked
        // so a following start edge is caught immediately.
        if (w_decide) begin
`ifdef SCARD_NACK_EN
          if (r_perr_pend) begin
            w_next = ST_NACK;
          end else begin
            w_next = ST_IDLE;
          end
`else
          w_next = ST_IDLE;
`endif
        end else begin
          w_next = ST_STOP;
        end
      end
`ifdef SCARD_NACK_EN
      ST_NACK: begin
        if (w_tick && (r_tick_cnt == TICK_NACK_LAST)) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_NACK;
        end
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Tick counter: the start-detection clock counts as tick 0; restarted at
  // the stop decision so NACK can count its own 16 ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= 4'd0;
    end else if (w_start) begin
      r_tick_cnt <= 4'd1;
    end else if (w_load) begin
      r_tick_cnt <= 4'd0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 4'd1;
    end
  end

  // Bit sampling, data shift register, bit counter and parity check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_perr_pend <= 1'b0;
    end else begin
      if (w_tick && (r_tick_cnt == TICK_SAMP0)) begin
        r_s7 <= w_rxd;
      end
      if (w_tick && (r_tick_cnt == TICK_SAMP1)) begin
        r_s8 <= w_rxd;
      end
      if (r_state == ST_START) begin
        r_bit_cnt <= 3'd0;
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == ST_DATA) && w_decide) begin
        r_shift <= {w_maj, r_shift[7:1]};
      end
      if ((r_state == ST_PARITY) && w_decide) begin
        r_perr_pend <= w_maj ^ (^r_shift);
      end
    end
  end

  // Host-visible outputs: data and flags change only together with the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= 8'h00;
      r_ready <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= w_load;
      r_busy  <= (w_next != ST_IDLE);
      if (w_load) begin
        r_data <= r_shift;
        r_perr <= r_perr_pend;
        r_ferr <= ~w_maj;
      end
    end
  end

`ifdef SCARD_NACK_EN
  logic r_nack_oe;

  // Error signal follows the NACK state, registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nack_oe <= 1'b0;
    end else begin
      r_nack_oe <= (w_next == ST_NACK);
    end
  end

  assign RxD_nack_oe = r_nack_oe;
`else
  assign RxD_nack_oe = 1'b0;
`endif

  assign RxD_data       = r_data;
  assign RxD_data_ready = r_ready;
  assign RxD_parity_err = r_perr;
  assign RxD_frame_err  = r_ferr;
  assign RxD_busy       = r_busy;

endmodule

// File: tb/tb_async_receiver_scard.sv
// -----------------------------------------------------------------------------
// tb_async_receiver_scard
// Directed bench for async_receiver_scard at CLK_FREQ=16 MHz, BAUD=1 MHz
// (one clock per oversample tick, 16 clocks = 160 time units per bit).
// Honours SCARD_NACK_EN for the error-signal expectations.
// -----------------------------------------------------------------------------
module tb_async_receiver_scard;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int BT       = 160;

  logic       clk;
  logic       reset_n;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_parity_err;
  logic       RxD_frame_err;
  logic       RxD_busy;
  logic       RxD_nack_oe;

  int n_tests = 0;
  int n_fail  = 0;

  async_receiver_scard #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DIV_W    (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .RxD            (RxD),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_parity_err (RxD_parity_err),
    .RxD_frame_err  (RxD_frame_err),
    .RxD_busy       (RxD_busy),
    .RxD_nack_oe    (RxD_nack_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitors sampled on the falling edge.
  int          pulse_cnt  = 0;
  int          ready_long = 0;
  int          busy_rise  = 0;
  int          nack_total = 0;
  int          nack_run   = 0;
  int          nack_last  = 0;
  logic        ready_prev = 1'b0;
  logic        busy_prev  = 1'b0;
  logic        nack_prev  = 1'b0;
  logic [7:0]  rx_log [0:15];
  longint      t_ready    = 0;
`ifdef SCARD_NACK_EN
  longint      t_nack     = 0;
`endif

  always @(negedge clk) begin
    if (RxD_data_ready) begin
      if (pulse_cnt < 16) rx_log[pulse_cnt] <= RxD_data;
      pulse_cnt <= pulse_cnt + 1;
      t_ready   <= $time;
    end
    if (RxD_data_ready && ready_prev) ready_long <= ready_long + 1;
    ready_prev <= RxD_data_ready;
    if (RxD_busy && !busy_prev) busy_rise <= busy_rise + 1;
    busy_prev <= RxD_busy;
    if (RxD_nack_oe) begin
      nack_total <= nack_total + 1;
      nack_run   <= nack_run + 1;
`ifdef SCARD_NACK_EN
      if (!nack_prev) t_nack <= $time;
`endif
    end else if (nack_prev) begin
      nack_last <= nack_run;
      nack_run  <= 0;
    end
    nack_prev <= RxD_nack_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bt);
    RxD = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      #(bt);
    end
    RxD = par;
    #(bt);
    RxD = stp;
    #(bt);
    RxD = 1'b1;
    #(bt);
  endtask

  int p0;
  int b0;

  initial begin
    RxD     = 1'b1;
    reset_n = 1'b0;
    #22;
    // Reset state
    check("rst_data",  32'(RxD_data),       32'h00);
    check("rst_ready", 32'(RxD_data_ready), 32'h0);
    check("rst_perr",  32'(RxD_parity_err), 32'h0);
    check("rst_ferr",  32'(RxD_frame_err),  32'h0);
    check("rst_busy",  32'(RxD_busy),       32'h0);
    check("rst_nack",  32'(RxD_nack_oe),    32'h0);
    reset_n = 1'b1;
    #100;

    // 1: 0xA5, even parity 0, good stop
    p0 = pulse_cnt;
    b0 = busy_rise;
    send_frame(8'hA5, 1'b0, 1'b1, BT);
    #100;
    check("t1_pulses", 32'(pulse_cnt),      32'(p0 + 1));
    check("t1_data",   32'(RxD_data),       32'hA5);
    check("t1_perr",   32'(RxD_parity_err), 32'h0);
    check("t1_ferr",   32'(RxD_frame_err),  32'h0);
    check("t1_busy",   32'(RxD_busy),       32'h0);
    check("t1_brise",  32'(busy_rise),      32'(b0 + 1));
    check("t1_nack",   32'(nack_total),     32'd0);

    // 2: 0x3C with wrong parity bit 1
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, BT);
    #100;
    check("t2_pulses", 32'(pulse_cnt),      32'(p0 + 1));
    check("t2_data",   32'(RxD_data),       32'h3C);
    check("t2_perr",   32'(RxD_parity_err), 32'h1);
    check("t2_ferr",   32'(RxD_frame_err),  32'h0);
`ifdef SCARD_NACK_EN
    check("t2_nack_len",   32'(nack_last),         32'd16);
    check("t2_nack_align", 32'(t_nack - t_ready),  32'd0);
`else
    check("t2_nack_total", 32'(nack_total), 32'd0);
`endif

    // 3: 0x00, parity 0, first stop bit low
    p0 = pulse_cnt;
    send_frame(8'h00, 1'b0, 1'b0, BT);
    #100;
    check("t3_pulses", 32'(pulse_cnt),      32'(p0 + 1));
    check("t3_data",   32'(RxD_data),       32'h00);
    check("t3_ferr",   32'(RxD_frame_err),  32'h1);
    check("t3_perr",   32'(RxD_parity_err), 32'h0);

    // 4: 4-clock low glitch on the idle line
    p0 = pulse_cnt;
    b0 = busy_rise;
    RxD = 1'b0;
    #40;
    RxD = 1'b1;
    #120;
    check("t4_busy16", 32'(RxD_busy),      32'h0);
    #100;
    check("t4_pulses", 32'(pulse_cnt),     32'(p0));
    check("t4_brise",  32'(busy_rise),     32'(b0 + 1));
    check("t4_data",   32'(RxD_data),      32'h00);
    check("t4_ferr",   32'(RxD_frame_err), 32'h1);

    // 5: 0x55 at +3% bit time then 0xAA at -3%, back to back
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 165);
    send_frame(8'hAA, 1'b0, 1'b1, 155);
    #100;
    check("t5_pulses", 32'(pulse_cnt),      32'(p0 + 2));
    check("t5_byte0",  32'(rx_log[p0]),     32'h55);
    check("t5_byte1",  32'(rx_log[p0 + 1]), 32'hAA);
    check("t5_perr",   32'(RxD_parity_err), 32'h0);
    check("t5_ferr",   32'(RxD_frame_err),  32'h0);
    check("t5_rdy1clk", 32'(ready_long),    32'd0);

    // 6: reset in the middle of 0xFF, line held low after release, then 0x81
    p0 = pulse_cnt;
    RxD = 1'b0;
    #(BT);
    RxD = 1'b1;
    #(4 * BT + BT / 2);
    reset_n = 1'b0;
    #20;
    check("t6_rst_data", 32'(RxD_data),      32'h00);
    check("t6_rst_busy", 32'(RxD_busy),      32'h0);
    check("t6_rst_ferr", 32'(RxD_frame_err), 32'h0);
    RxD = 1'b0;
    #4;
    reset_n = 1'b1;
    #200;
    check("t6_hold_pulses", 32'(pulse_cnt), 32'(p0));
    check("t6_hold_busy",   32'(RxD_busy),  32'h0);
    RxD = 1'b1;
    #(BT);
    send_frame(8'h81, 1'b0, 1'b1, BT);
    #100;
    check("t6_pulses", 32'(pulse_cnt),      32'(p0 + 1));
    check("t6_data",   32'(RxD_data),       32'h81);
    check("t6_perr",   32'(RxD_parity_err), 32'h0);
    check("t6_ferr",   32'(RxD_frame_err),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
